// File: rtl/bp_ctrl_pkg.sv
// Shared sizing, FSM state type and the saturating drop-counter helper for the BHT sequencer.
package bp_ctrl_pkg;

    localparam int unsigned BHT_ABITS     = 6;
    localparam int unsigned BHT_MEM_ABITS = 4;
    localparam int unsigned DCNT_BITS     = 8;

    typedef logic [1:0] bp_state_t;

    function automatic logic [DCNT_BITS-1:0] sat_add(input logic [DCNT_BITS-1:0] cnt,
                                                     input logic [1:0]           inc);
        logic [DCNT_BITS:0] sum;
        sum = {1'b0, cnt} + {{(DCNT_BITS-1){1'b0}}, inc};
        return sum[DCNT_BITS] ? '1 : sum[DCNT_BITS-1:0];
    endfunction

endpackage

// File: rtl/bp_ctrl_if.sv
// Update-request, flush and bp_base-facing signals of the BHT sequencer.
interface bp_ctrl_if;
    import bp_ctrl_pkg::*;

    logic                     flush_req;
    logic                     flush_ack;
    logic                     bp_ready;
    logic                     upd0_valid;
    logic [BHT_ABITS-1:0]     upd0_index;
    logic                     upd0_taken;
    logic                     upd0_ready;
    logic                     upd1_valid;
    logic [BHT_ABITS-1:0]     upd1_index;
    logic                     upd1_taken;
    logic                     upd1_ready;
    logic                     bp_init_active;
    logic [BHT_MEM_ABITS-1:0] bp_init_index;
    logic                     bp_update;
    logic [BHT_ABITS-1:0]     bp_update_index;
    logic                     bp_update_taken;
    logic [DCNT_BITS-1:0]     drop_cnt;

    modport slave (
        input  flush_req, upd0_valid, upd0_index, upd0_taken, upd1_valid, upd1_index, upd1_taken,
        output flush_ack, bp_ready, upd0_ready, upd1_ready, bp_init_active, bp_init_index,
               bp_update, bp_update_index, bp_update_taken, drop_cnt
    );

    modport master (
        output flush_req, upd0_valid, upd0_index, upd0_taken, upd1_valid, upd1_index, upd1_taken,
        input  flush_ack, bp_ready, upd0_ready, upd1_ready, bp_init_active, bp_init_index,
               bp_update, bp_update_index, bp_update_taken, drop_cnt
    );

endinterface

// File: rtl/bp_upd_arb.sv
// Two 1-entry update buffers, round-robin grant and the registered bp_update output stage.
module bp_upd_arb
    import bp_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_run,
    input  logic                 i_clear,
    input  logic                 i_upd0_valid,
    input  logic [BHT_ABITS-1:0] i_upd0_index,
    input  logic                 i_upd0_taken,
    input  logic                 i_upd1_valid,
    input  logic [BHT_ABITS-1:0] i_upd1_index,
    input  logic                 i_upd1_taken,
    output logic                 o_upd0_ready,
    output logic                 o_upd1_ready,
    output logic [1:0]           o_accept,
    output logic                 o_update,
    output logic [BHT_ABITS-1:0] o_update_index,
    output logic                 o_update_taken
);

    logic [1:0]           r_buf_valid;
    logic [BHT_ABITS-1:0] r_buf0_index;
    logic [BHT_ABITS-1:0] r_buf1_index;
    logic [1:0]           r_buf_taken;
    logic                 r_rr_last;
    logic                 r_update;
    logic [BHT_ABITS-1:0] r_update_index;
    logic                 r_update_taken;

    logic [1:0] w_grant;
    logic [1:0] w_ready;
    logic [1:0] w_accept;
    logic       w_issue;

    // Grant is a function of registered state only, so ready never depends on valid.
    always_comb begin
        w_grant = r_buf_valid;
        if (&r_buf_valid) begin
            w_grant = r_rr_last ? 2'b01 : 2'b10;
        end
    end

    assign w_ready  = i_run ? (~r_buf_valid | w_grant) : 2'b11;
    assign w_accept = {i_upd1_valid, i_upd0_valid} & w_ready;
    assign w_issue  = i_run && !i_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid    <= 2'b00;
            r_buf0_index   <= '0;
            r_buf1_index   <= '0;
            r_buf_taken    <= 2'b00;
            r_rr_last      <= 1'b1;
            r_update       <= 1'b0;
            r_update_index <= '0;
            r_update_taken <= 1'b0;
        end else if (!w_issue) begin
            r_buf_valid <= 2'b00;
            r_update    <= 1'b0;
        end else begin
            if (w_accept[0]) begin
                r_buf_valid[0] <= 1'b1;
                r_buf0_index   <= i_upd0_index;
                r_buf_taken[0] <= i_upd0_taken;
            end else if (w_grant[0]) begin
                r_buf_valid[0] <= 1'b0;
            end
            if (w_accept[1]) begin
                r_buf_valid[1] <= 1'b1;
                r_buf1_index   <= i_upd1_index;
                r_buf_taken[1] <= i_upd1_taken;
            end else if (w_grant[1]) begin
                r_buf_valid[1] <= 1'b0;
            end
            r_update <= |w_grant;
            if (w_grant[0]) begin
                r_update_index <= r_buf0_index;
                r_update_taken <= r_buf_taken[0];
            end else if (w_grant[1]) begin
                r_update_index <= r_buf1_index;
                r_update_taken <= r_buf_taken[1];
            end
            if (|w_grant) begin
                r_rr_last <= w_grant[1];
            end
        end
    end

    assign o_upd0_ready   = w_ready[0];
    assign o_upd1_ready   = w_ready[1];
    assign o_accept       = w_accept;
    assign o_update       = r_update;
    assign o_update_index = r_update_index;
    assign o_update_taken = r_update_taken;

endmodule

// File: rtl/bp_ctrl.sv
// BHT sequencer: init sweep FSM, flush handling, drop counting, and the two-port update merge.
module bp_ctrl
    import bp_ctrl_pkg::*;
(
    input logic       clk,
    input logic       rst,
    bp_ctrl_if.slave  bus
);

    localparam bp_state_t ST_START = 2'd0;
    localparam bp_state_t ST_INIT  = 2'd1;
    localparam bp_state_t ST_RUN   = 2'd2;

    bp_state_t                r_state;
    logic [BHT_MEM_ABITS-1:0] r_init_idx;
    logic                     r_flush_ack;
    logic [DCNT_BITS-1:0]     r_drop_cnt;

    logic       w_run;
    logic       w_flush;
    logic [1:0] w_accept;
    logic [1:0] w_drop_n;

    assign w_run    = (r_state == ST_RUN);
    assign w_flush  = w_run && bus.flush_req;
    assign w_drop_n = {1'b0, w_accept[0]} + {1'b0, w_accept[1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_START;
            r_init_idx  <= '0;
            r_flush_ack <= 1'b0;
        end else begin
            r_flush_ack <= (r_state == ST_INIT) && (&r_init_idx);
            case (r_state)
                ST_START: r_state <= ST_INIT;
                ST_INIT: begin
                    r_init_idx <= r_init_idx + 1'b1;
                    if (&r_init_idx) begin
                        r_state    <= ST_RUN;
                        r_init_idx <= '0;
                    end
                end
                ST_RUN: begin
                    if (bus.flush_req) begin
                        r_state <= ST_INIT;
                    end
                end
                default: r_state <= ST_START;
            endcase
        end
    end

    // Anything accepted while the table is not in service (including the flush cycle) is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (!w_run || w_flush) begin
            r_drop_cnt <= sat_add(r_drop_cnt, w_drop_n);
        end
    end

    bp_upd_arb u_arb (
        .clk            (clk),
        .rst            (rst),
        .i_run          (w_run),
        .i_clear        (w_flush),
        .i_upd0_valid   (bus.upd0_valid),
        .i_upd0_index   (bus.upd0_index),
        .i_upd0_taken   (bus.upd0_taken),
        .i_upd1_valid   (bus.upd1_valid),
        .i_upd1_index   (bus.upd1_index),
        .i_upd1_taken   (bus.upd1_taken),
        .o_upd0_ready   (bus.upd0_ready),
        .o_upd1_ready   (bus.upd1_ready),
        .o_accept       (w_accept),
        .o_update       (bus.bp_update),
        .o_update_index (bus.bp_update_index),
        .o_update_taken (bus.bp_update_taken)
    );

    assign bus.flush_ack      = r_flush_ack;
    assign bus.bp_ready       = w_run;
    assign bus.bp_init_active = (r_state == ST_INIT);
    assign bus.bp_init_index  = r_init_idx;
    assign bus.drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_bp_ctrl.sv
// Directed bench for bp_ctrl: sweep, latency, round-robin, flush drop, saturation, async reset.
module tb_bp_ctrl;
    import bp_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    bp_ctrl_if bus ();

    bp_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int   i0;
        int   i1;
        int   n;
        logic a0;
        logic a1;

        bus.flush_req  = 1'b0;
        bus.upd0_valid = 1'b0;
        bus.upd0_index = '0;
        bus.upd0_taken = 1'b0;
        bus.upd1_valid = 1'b0;
        bus.upd1_index = '0;
        bus.upd1_taken = 1'b0;

        // T1: reset values, START cycle, 16-cycle sweep, flush_ack pulse
        @(negedge clk);
        chk("rst_init_active", 32'(bus.bp_init_active), 32'd0);
        chk("rst_bp_ready",    32'(bus.bp_ready),       32'd0);
        chk("rst_bp_update",   32'(bus.bp_update),      32'd0);
        chk("rst_flush_ack",   32'(bus.flush_ack),      32'd0);
        chk("rst_drop_cnt",    32'(bus.drop_cnt),       32'd0);
        rst = 1'b0;
        chk("start_init_active", 32'(bus.bp_init_active), 32'd0);
        step();
        for (int k = 0; k < 16; k++) begin
            chk("t1_init_index",  32'(bus.bp_init_index),  32'(k));
            chk("t1_init_active", 32'(bus.bp_init_active), 32'd1);
            chk("t1_not_ready",   32'(bus.bp_ready),       32'd0);
            step();
        end
        chk("t1_flush_ack",   32'(bus.flush_ack),      32'd1);
        chk("t1_bp_ready",    32'(bus.bp_ready),       32'd1);
        chk("t1_init_done",   32'(bus.bp_init_active), 32'd0);
        step();
        chk("t1_flush_ack_1cyc", 32'(bus.flush_ack), 32'd0);

        // T3: both ports valid every cycle -> p0,p1 alternate starting with p0
        i0 = 1;
        i1 = 33;
        for (int k = 0; k < 10; k++) begin
            bus.upd0_valid = 1'b1;
            bus.upd0_index = 6'(i0);
            bus.upd0_taken = 1'b1;
            bus.upd1_valid = 1'b1;
            bus.upd1_index = 6'(i1);
            bus.upd1_taken = 1'b0;
            if (k == 0) begin
                chk("t3_ready0", 32'(bus.upd0_ready), 32'd1);
                chk("t3_ready1", 32'(bus.upd1_ready), 32'd1);
            end else begin
                chk("t3_ready0", 32'(bus.upd0_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
                chk("t3_ready1", 32'(bus.upd1_ready), (k % 2 == 1) ? 32'd0 : 32'd1);
            end
            if (k >= 2) begin
                chk("t3_update", 32'(bus.bp_update), 32'd1);
                chk("t3_index", 32'(bus.bp_update_index),
                    (k % 2 == 0) ? 32'(1 + (k - 2) / 2) : 32'(33 + (k - 2) / 2));
                chk("t3_taken", 32'(bus.bp_update_taken), (k % 2 == 0) ? 32'd1 : 32'd0);
            end else begin
                chk("t3_update_idle", 32'(bus.bp_update), 32'd0);
            end
            a0 = bus.upd0_valid && bus.upd0_ready;
            a1 = bus.upd1_valid && bus.upd1_ready;
            step();
            if (a0) i0++;
            if (a1) i1++;
        end
        bus.upd0_valid = 1'b0;
        bus.upd1_valid = 1'b0;
        repeat (4) step();
        chk("t3_drained",  32'(bus.bp_update), 32'd0);
        chk("t3_no_drops", 32'(bus.drop_cnt),  32'd0);

        // T2: single update, 2-cycle latency, 1-cycle strobe
        bus.upd0_valid = 1'b1;
        bus.upd0_index = 6'h05;
        bus.upd0_taken = 1'b1;
        chk("t2_ready0", 32'(bus.upd0_ready), 32'd1);
        step();
        bus.upd0_valid = 1'b0;
        chk("t2_n1_update", 32'(bus.bp_update), 32'd0);
        step();
        chk("t2_n2_update", 32'(bus.bp_update),       32'd1);
        chk("t2_n2_index",  32'(bus.bp_update_index), 32'h05);
        chk("t2_n2_taken",  32'(bus.bp_update_taken), 32'd1);
        step();
        chk("t2_n3_update", 32'(bus.bp_update), 32'd0);

        // T4: flush with p1 buffer full; buffered entry lost, 3 mid-sweep drops
        bus.upd1_valid = 1'b1;
        bus.upd1_index = 6'h07;
        bus.upd1_taken = 1'b1;
        step();
        bus.upd1_valid = 1'b0;
        bus.flush_req  = 1'b1;
        step();
        bus.flush_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.upd0_valid = (k >= 4 && k <= 6);
            bus.upd0_index = 6'(k);
            chk("t4_init_index", 32'(bus.bp_init_index), 32'(k));
            chk("t4_no_update",  32'(bus.bp_update),     32'd0);
            if (k >= 4 && k <= 6) chk("t4_ready0", 32'(bus.upd0_ready), 32'd1);
            if (k == 0) chk("t4_ready1", 32'(bus.upd1_ready), 32'd1);
            step();
        end
        bus.upd0_valid = 1'b0;
        chk("t4_flush_ack", 32'(bus.flush_ack), 32'd1);
        chk("t4_bp_ready",  32'(bus.bp_ready),  32'd1);
        chk("t4_drop_cnt",  32'(bus.drop_cnt),  32'd3);
        chk("t4_no_update", 32'(bus.bp_update), 32'd0);
        step();

        // T5: flush held, both ports valid for 200 cycles -> +2 per cycle, saturate at FF
        bus.flush_req  = 1'b1;
        bus.upd0_valid = 1'b1;
        bus.upd1_valid = 1'b1;
        repeat (50) step();
        chk("t5_drop_50",  32'(bus.drop_cnt), 32'd103);
        repeat (75) step();
        chk("t5_drop_125", 32'(bus.drop_cnt), 32'd253);
        step();
        chk("t5_drop_126", 32'(bus.drop_cnt), 32'hFF);
        repeat (74) step();
        chk("t5_drop_sat", 32'(bus.drop_cnt), 32'hFF);
        bus.flush_req  = 1'b0;
        bus.upd0_valid = 1'b0;
        bus.upd1_valid = 1'b0;
        n = 0;
        while (!bus.bp_ready && n < 40) begin
            step();
            n++;
        end
        chk("t5_back_to_run", 32'(bus.bp_ready), 32'd1);
        step();

        // T6: async reset at init_idx 9, sweep restarts from 0
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        repeat (9) step();
        chk("t6_idx9", 32'(bus.bp_init_index), 32'd9);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_active",    32'(bus.bp_init_active), 32'd0);
        chk("t6_rst_index",     32'(bus.bp_init_index),  32'd0);
        chk("t6_rst_ready",     32'(bus.bp_ready),       32'd0);
        chk("t6_rst_drop",      32'(bus.drop_cnt),       32'd0);
        chk("t6_rst_update",    32'(bus.bp_update),      32'd0);
        chk("t6_rst_flush_ack", 32'(bus.flush_ack),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_start", 32'(bus.bp_init_active), 32'd0);
        step();
        chk("t6_restart_idx0",   32'(bus.bp_init_index),  32'd0);
        chk("t6_restart_active", 32'(bus.bp_init_active), 32'd1);
        step();
        chk("t6_restart_idx1",   32'(bus.bp_init_index),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
